// File: rtl/overlay_source_pkg.sv
// Shared definitions for the overlay source: FSM encoding and pixel packing offsets.
// Packed pixel layout is {A, ch2, ch1, ch0} with ch0 in the LSBs.
package overlay_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  localparam int OVL_NUM_CH = 3;

  // LSB of colour channel ch inside a packed pixel
  function automatic int ovl_ch_lsb(input int ch, input int pw);
    return ch * pw;
  endfunction

  // LSB of the alpha field inside a packed pixel
  function automatic int ovl_a_lsb(input int pw);
    return OVL_NUM_CH * pw;
  endfunction

endpackage

// File: rtl/overlay_fifo.sv
// Synchronous show-ahead FIFO with clear, occupancy count and simultaneous push/pop.
// Head data reads as zero while empty so downstream sees a transparent pixel.
module overlay_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          wr_en, rd_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign count = cnt_q;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign wr_en = push && (!full || pop) && !clr;
  assign rd_en = pop && !empty && !clr;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // storage array, no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  // pointers and occupancy; clear wins over push/pop
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

endmodule

// File: rtl/overlay_source.sv
// Overlay stream producer: prefetches packed pixels from memory into a show-ahead
// FIFO and presents the head to the blender, which pops with overlay_adv.
// Optional colour key: define OVERLAY_SRC_COLORKEY_EN to add key_color and force
// alpha to 0 for pixels whose colour equals the key.
module overlay_source
  import overlay_source_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int ALPHA_WIDTH = 8,
  parameter int DIM_WIDTH   = 11,
  parameter int ADDR_WIDTH  = 24,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                                         clk,
  input  logic                                         resetb,
  input  logic                                         enable,
  input  logic [ADDR_WIDTH-1:0]                        base_addr,
  input  logic [DIM_WIDTH-1:0]                         num_overlay_rows,
  input  logic [DIM_WIDTH-1:0]                         num_overlay_cols,
  input  logic                                         overlay_adv,
  input  logic                                         overlay_restart,
  output logic [PIXEL_WIDTH-1:0]                       overlay0,
  output logic [PIXEL_WIDTH-1:0]                       overlay1,
  output logic [PIXEL_WIDTH-1:0]                       overlay2,
  output logic [ALPHA_WIDTH-1:0]                       overlayA,
  output logic                                         underflow,
  output logic                                         rd_req,
  output logic [ADDR_WIDTH-1:0]                        rd_addr,
  input  logic                                         rd_ack,
  input  logic                                         rd_valid,
`ifdef OVERLAY_SRC_COLORKEY_EN
  input  logic [OVL_NUM_CH*PIXEL_WIDTH-1:0]            key_color,
`endif
  input  logic [OVL_NUM_CH*PIXEL_WIDTH+ALPHA_WIDTH-1:0] rd_data
);
  localparam int DW     = OVL_NUM_CH*PIXEL_WIDTH + ALPHA_WIDTH;
  localparam int CH0    = ovl_ch_lsb(0, PIXEL_WIDTH);
  localparam int CH1    = ovl_ch_lsb(1, PIXEL_WIDTH);
  localparam int CH2    = ovl_ch_lsb(2, PIXEL_WIDTH);
  localparam int A_LSB  = ovl_a_lsb(PIXEL_WIDTH);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int TW     = 2*DIM_WIDTH;

  state_t                state_q;
  logic                  rd_req_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [TW-1:0]         issued_q;
  logic [CW-1:0]         out_q;
  logic                  under_q;

  logic                  ack, hold_req, active, restart_go;
  logic                  fifo_clr, push, pop, credit_ok;
  logic [CW-1:0]         fifo_cnt, cnt_nxt, out_d;
  logic [TW-1:0]         total, issued_inc;
  logic [DW-1:0]         wdata, head;
  logic                  fifo_empty, fifo_full;

  assign total = TW'(num_overlay_rows) * TW'(num_overlay_cols);

  // colour key: matching colour is stored fully transparent
`ifdef OVERLAY_SRC_COLORKEY_EN
  logic key_hit;
  assign key_hit = (rd_data[A_LSB-1:0] == key_color);
  assign wdata   = {key_hit ? {ALPHA_WIDTH{1'b0}} : rd_data[A_LSB +: ALPHA_WIDTH],
                    rd_data[A_LSB-1:0]};
`else
  assign wdata   = rd_data;
`endif

  // FIFO control, outstanding tracking and the credit check on next-cycle occupancy
  always_comb begin
    ack        = rd_req_q & rd_ack;
    hold_req   = rd_req_q & ~rd_ack;
    active     = enable && (state_q == ST_STREAM || state_q == ST_DONE);
    restart_go = active && overlay_restart;
    fifo_clr   = !enable || (state_q == ST_IDLE) || restart_go;
    push       = active && !restart_go && rd_valid;
    pop        = enable && !restart_go && overlay_adv && !fifo_empty;
    out_d      = out_q + CW'(ack) - CW'(rd_valid && (out_q != '0));
    cnt_nxt    = fifo_clr ? '0 : fifo_cnt + CW'(push) - CW'(pop);
    issued_inc = issued_q + TW'(ack);
    // reserve a slot for every read in flight so the FIFO can never overflow
    credit_ok  = (({1'b0, cnt_nxt} + {1'b0, out_d}) < (CW+1)'(FIFO_DEPTH)) &&
                 (issued_inc < total);
  end

  // stream FSM with registered request, address, counters and sticky underflow
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= ST_IDLE;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      issued_q  <= '0;
      out_q     <= '0;
      under_q   <= 1'b0;
    end else begin
      // returns are always counted, even while idle or disabled
      out_q <= out_d;
      if (!enable) begin
        state_q  <= ST_IDLE;
        rd_req_q <= 1'b0;
        issued_q <= '0;
        under_q  <= 1'b0;
      end else begin
        if (overlay_adv && fifo_empty && !restart_go) under_q <= 1'b1;
        case (state_q)
          ST_IDLE: begin
            rd_req_q <= 1'b0;
            issued_q <= '0;
            // reads dropped at disable must drain before a new pass starts
            if (out_q == '0) state_q <= ST_STREAM;
          end
          ST_STREAM: begin
            if (restart_go) begin
              issued_q <= '0;
              rd_req_q <= hold_req;
              // a still-pending request belongs to the old pass, flush it too
              state_q  <= (out_d != '0 || hold_req) ? ST_FLUSH : ST_STREAM;
            end else begin
              issued_q <= issued_inc;
              if (hold_req) begin
                rd_req_q <= 1'b1;
              end else if (credit_ok) begin
                rd_req_q  <= 1'b1;
                rd_addr_q <= base_addr + ADDR_WIDTH'(issued_inc);
              end else begin
                rd_req_q <= 1'b0;
              end
              if (total != '0 && issued_q == total && out_q == '0 && !rd_req_q)
                state_q <= ST_DONE;
            end
          end
          ST_DONE: begin
            rd_req_q <= 1'b0;
            if (restart_go) begin
              issued_q <= '0;
              state_q  <= (out_d != '0) ? ST_FLUSH : ST_STREAM;
            end
          end
          ST_FLUSH: begin
            rd_req_q <= hold_req;
            issued_q <= '0;
            if (out_d == '0 && !hold_req) state_q <= ST_STREAM;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  overlay_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetb (resetb),
    .clr    (fifo_clr),
    .push   (push),
    .pop    (pop),
    .wdata  (wdata),
    .rdata  (head),
    .count  (fifo_cnt),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // full is implied by the credit rule; kept on the FIFO for reuse
  logic unused_full;
  assign unused_full = fifo_full;

  assign overlay0  = head[CH0 +: PIXEL_WIDTH];
  assign overlay1  = head[CH1 +: PIXEL_WIDTH];
  assign overlay2  = head[CH2 +: PIXEL_WIDTH];
  assign overlayA  = head[A_LSB +: ALPHA_WIDTH];
  assign underflow = under_q;
  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_overlay_source.sv
// Directed bench for overlay_source with a 4-entry FIFO and a behavioural memory
// that acks combinationally and returns data a programmable number of cycles later.
module tb_overlay_source;
  logic        clk = 1'b0;
  logic        resetb, enable, adv, restart;
  logic [23:0] base_addr;
  logic [10:0] rows, cols;
  logic [7:0]  ovl0, ovl1, ovl2, ovlA;
  logic        underflow, rd_req, rd_ack, rd_valid;
  logic [23:0] rd_addr;
  logic [31:0] rd_data;
`ifdef OVERLAY_SRC_COLORKEY_EN
  logic [23:0] key_color = 24'h00FF00;
`endif

  int errors = 0;
  int checks = 0;

  // memory model controls, written only by the stimulus process
  logic        ack_en = 1'b1;
  logic        hold_valid = 1'b0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr0 = '0, ovr1 = '0;
  logic [7:0]  gen = '0;
  int          lat = 3;

  typedef struct { logic [31:0] d; int due; } rsp_t;
  rsp_t        rq[$];
  logic [23:0] addr_log[$];
  int          cyc = 0;

  always #5 clk = ~clk;
  assign rd_ack = ack_en & rd_req;

  overlay_source #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .base_addr(base_addr),
    .num_overlay_rows(rows), .num_overlay_cols(cols),
    .overlay_adv(adv), .overlay_restart(restart),
    .overlay0(ovl0), .overlay1(ovl1), .overlay2(ovl2), .overlayA(ovlA),
    .underflow(underflow), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid),
`ifdef OVERLAY_SRC_COLORKEY_EN
    .key_color(key_color),
`endif
    .rd_data(rd_data)
  );

  function automatic logic [31:0] pix(input logic [23:0] a, input logic [7:0] g);
    return {1'b1, a[6:0], g, a[15:8], a[7:0]};
  endfunction

  // memory responder: in-order returns, lat cycles after the accepting edge
  always @(negedge clk) begin
    cyc++;
    if (!resetb) begin
      rq.delete();
      rd_valid = 1'b0;
      rd_data  = '0;
    end else begin
      if (!hold_valid && rq.size() > 0 && rq[0].due <= cyc) begin
        rd_valid = 1'b1;
        rd_data  = rq[0].d;
        void'(rq.pop_front());
      end else begin
        rd_valid = 1'b0;
      end
      if (rd_req && rd_ack) begin
        rq.push_back('{d: ovr_en ? (rd_addr[0] ? ovr1 : ovr0) : pix(rd_addr, gen),
                       due: cyc + lat});
        addr_log.push_back(rd_addr);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_adv();
    adv = 1'b1; tick(1); adv = 1'b0;
  endtask

  task automatic wait_head(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (ovlA != 8'h00) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic do_reset();
    resetb = 1'b0; enable = 1'b0; adv = 1'b0; restart = 1'b0;
    ack_en = 1'b1; hold_valid = 1'b0; ovr_en = 1'b0; gen = 8'h00; lat = 3;
    base_addr = '0; rows = '0; cols = '0;
    tick(2);
    resetb = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    resetb = 1'b0; enable = 1'b0; adv = 1'b0; restart = 1'b0;
    base_addr = 24'hABCDEF; rows = 11'd5; cols = 11'd5;
    tick(2);
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req got=%b exp=0", rd_req); end
    checks++; if (rd_addr !== 24'h0) begin errors++; $display("FAIL reset_rd_addr got=%h exp=000000", rd_addr); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    checks++; if ({ovlA, ovl2, ovl1, ovl0} !== 32'h0) begin errors++; $display("FAIL reset_head got=%h exp=00000000", {ovlA, ovl2, ovl1, ovl0}); end
    resetb = 1'b1; tick(3);
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL idle_no_req got=%b exp=0", rd_req); end
  endtask

  task automatic test_stream();
    int mark; bit ok;
    do_reset();
    mark = addr_log.size();
    base_addr = 24'h000100; rows = 11'd2; cols = 11'd3; lat = 3;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_head(40, ok);
      checks++;
      if (!ok || {ovlA, ovl2, ovl1, ovl0} !== pix(24'h100 + 24'(i), 8'h00)) begin
        errors++;
        $display("FAIL stream_pop%0d got=%h exp=%h", i, {ovlA, ovl2, ovl1, ovl0}, pix(24'h100 + 24'(i), 8'h00));
      end
      pulse_adv();
    end
    tick(20);
    checks++; if (addr_log.size() - mark != 6) begin errors++; $display("FAIL stream_nreads got=%0d exp=6", addr_log.size() - mark); end
    for (int i = 0; i < 6 && mark + i < addr_log.size(); i++) begin
      checks++;
      if (addr_log[mark+i] !== 24'h100 + 24'(i)) begin
        errors++; $display("FAIL stream_addr%0d got=%h exp=%h", i, addr_log[mark+i], 24'h100 + 24'(i));
      end
    end
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL done_rd_req got=%b exp=0", rd_req); end
    checks++; if (ovlA !== 8'h00) begin errors++; $display("FAIL done_transparent got=%h exp=00", ovlA); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL stream_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_credit();
    int mark; bit ok;
    do_reset();
    mark = addr_log.size();
    base_addr = 24'h000040; rows = 11'd4; cols = 11'd4; lat = 2;
    enable = 1'b1;
    tick(30);
    checks++; if (addr_log.size() - mark != 4) begin errors++; $display("FAIL credit_nreads got=%0d exp=4", addr_log.size() - mark); end
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL credit_rd_req got=%b exp=0", rd_req); end
    for (int i = 0; i < 4; i++) begin
      wait_head(20, ok);
      checks++;
      if (!ok || {ovlA, ovl2, ovl1, ovl0} !== pix(24'h40 + 24'(i), 8'h00)) begin
        errors++;
        $display("FAIL credit_pop%0d got=%h exp=%h", i, {ovlA, ovl2, ovl1, ovl0}, pix(24'h40 + 24'(i), 8'h00));
      end
      pulse_adv();
    end
    tick(20);
    checks++; if (addr_log.size() - mark != 8) begin errors++; $display("FAIL credit_refill got=%0d exp=8", addr_log.size() - mark); end
  endtask

  task automatic test_underflow();
    int mark;
    do_reset();
    mark = addr_log.size();
    base_addr = 24'h000010; rows = 11'd0; cols = 11'd7;
    enable = 1'b1;
    tick(8);
    checks++; if (addr_log.size() - mark != 0 || rd_req !== 1'b0) begin errors++; $display("FAIL zero_total_reads got=%0d exp=0", addr_log.size() - mark); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_before got=%b exp=0", underflow); end
    pulse_adv();
    checks++; if (ovlA !== 8'h00) begin errors++; $display("FAIL uf_alpha got=%h exp=00", ovlA); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set got=%b exp=1", underflow); end
    tick(5);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got=%b exp=1", underflow); end
    enable = 1'b0; tick(1);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got=%b exp=0", underflow); end
  endtask

  task automatic test_restart_flush();
    int mark; bit ok;
    do_reset();
    mark = addr_log.size();
    base_addr = 24'h000300; rows = 11'd1; cols = 11'd3; lat = 3;
    hold_valid = 1'b1;
    enable = 1'b1;
    tick(12);
    checks++; if (addr_log.size() - mark != 3 || rd_req !== 1'b0) begin errors++; $display("FAIL flush_pre_reads got=%0d exp=3", addr_log.size() - mark); end
    restart = 1'b1; gen = 8'h01; tick(1); restart = 1'b0;
    hold_valid = 1'b0;
    wait_head(60, ok);
    checks++;
    if (!ok || {ovlA, ovl2, ovl1, ovl0} !== pix(24'h300, 8'h01)) begin
      errors++; $display("FAIL flush_first_pop got=%h exp=%h", {ovlA, ovl2, ovl1, ovl0}, pix(24'h300, 8'h01));
    end
    checks++;
    if (addr_log.size() - mark < 4 || addr_log[mark+3] !== 24'h300) begin
      errors++; $display("FAIL flush_rewind_addr got=%h exp=000300", (addr_log.size() - mark >= 4) ? addr_log[mark+3] : 24'hxxxxxx);
    end
    pulse_adv();
    wait_head(20, ok);
    checks++;
    if (!ok || {ovlA, ovl2, ovl1, ovl0} !== pix(24'h301, 8'h01)) begin
      errors++; $display("FAIL flush_second_pop got=%h exp=%h", {ovlA, ovl2, ovl1, ovl0}, pix(24'h301, 8'h01));
    end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL flush_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_restart_adv();
    bit ok;
    do_reset();
    base_addr = 24'h000500; rows = 11'd1; cols = 11'd2; lat = 1;
    enable = 1'b1;
    tick(12);
    checks++;
    if ({ovlA, ovl2, ovl1, ovl0} !== pix(24'h500, 8'h00)) begin
      errors++; $display("FAIL radv_pre got=%h exp=%h", {ovlA, ovl2, ovl1, ovl0}, pix(24'h500, 8'h00));
    end
    restart = 1'b1; adv = 1'b1; gen = 8'h02; tick(1); restart = 1'b0; adv = 1'b0;
    checks++; if (ovlA !== 8'h00) begin errors++; $display("FAIL radv_cleared got=%h exp=00", ovlA); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL radv_underflow got=%b exp=0", underflow); end
    wait_head(30, ok);
    checks++;
    if (!ok || {ovlA, ovl2, ovl1, ovl0} !== pix(24'h500, 8'h02)) begin
      errors++; $display("FAIL radv_rewind got=%h exp=%h", {ovlA, ovl2, ovl1, ovl0}, pix(24'h500, 8'h02));
    end
    pulse_adv();
    wait_head(20, ok);
    checks++;
    if (!ok || {ovlA, ovl2, ovl1, ovl0} !== pix(24'h501, 8'h02)) begin
      errors++; $display("FAIL radv_next got=%h exp=%h", {ovlA, ovl2, ovl1, ovl0}, pix(24'h501, 8'h02));
    end
  endtask

  task automatic test_colorkey();
    logic [31:0] exp0;
    do_reset();
`ifdef OVERLAY_SRC_COLORKEY_EN
    exp0 = 32'h0000FF00;
`else
    exp0 = 32'hC800FF00;
`endif
    ovr_en = 1'b1; ovr0 = 32'hC800FF00; ovr1 = 32'hC8010203;
    base_addr = 24'h000200; rows = 11'd1; cols = 11'd2; lat = 2;
    enable = 1'b1;
    tick(15);
    checks++;
    if ({ovlA, ovl2, ovl1, ovl0} !== exp0) begin
      errors++; $display("FAIL key_match got=%h exp=%h", {ovlA, ovl2, ovl1, ovl0}, exp0);
    end
    pulse_adv();
    checks++;
    if ({ovlA, ovl2, ovl1, ovl0} !== 32'hC8010203) begin
      errors++; $display("FAIL key_nomatch got=%h exp=c8010203", {ovlA, ovl2, ovl1, ovl0});
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_credit();
    test_underflow();
    test_restart_flush();
    test_restart_adv();
    test_colorkey();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
